hazard_ctrl: RTL and testbench

// - Pipeline hazard/stall controller; drives en/clear of IF/ID and ID/EX pipeline registers plus PC hold.
// - Detects load-use and control hazards; freezes pipeline on data-memory wait (dmem_ready handshake).
// - Small FSM tracks memory-wait duration, timeout halt and saturating stall/flush perf counters.

---
 rtl/hazard_ctrl_pkg.sv | 10 +
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the register-control outputs it receives back.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);

    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [1:0]       RegReadD;
    logic [4:0]       RdE;
    logic [2:0]       RegWriteE;
    logic             MemToRegE;
    logic             JalD;
    logic             BranchTakenE;
    logic             JalrE;
    logic             MemReqM;
    logic             dmem_ready;

    logic             StallPC;
    logic             IFID_en;
    logic             IFID_clear;
    logic             IDEX_en;
    logic             IDEX_clear;
    logic             EXMEM_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output Rs1D, Rs2D, RegReadD, RdE, RegWriteE, MemToRegE,
               JalD, BranchTakenE, JalrE, MemReqM, dmem_ready,
        input  StallPC, IFID_en, IFID_clear, IDEX_en, IDEX_clear,
               EXMEM_en, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, RegReadD, RdE, RegWriteE, MemToRegE,
               JalD, BranchTakenE, JalrE, MemReqM, dmem_ready,
        output StallPC, IFID_en, IFID_clear, IDEX_en, IDEX_clear,
               EXMEM_en, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, control-flow squashes,
// dmem-wait freezes with timeout halt, and saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int             WW   = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0]  WLIM = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0]  WONE = WW'(1);

    state_t        state;
    logic [WW-1:0] wcnt;
    logic          lu;
    logic          mw;
    logic          ctl;
    logic          stall_inc;
    logic          flush_inc;

    always_comb begin
        lu  = hz.MemToRegE && (|hz.RegWriteE) && (hz.RdE != 5'd0) &&
              ((hz.RegReadD[1] && (hz.Rs1D == hz.RdE)) ||
               (hz.RegReadD[0] && (hz.Rs2D == hz.RdE)));
        mw  = hz.MemReqM && !hz.dmem_ready;
        ctl = hz.BranchTakenE || hz.JalrE;

        hz.StallPC    = 1'b0;
        hz.IFID_en    = 1'b1;
        hz.IFID_clear = 1'b0;
        hz.IDEX_en    = 1'b1;
        hz.IDEX_clear = 1'b0;
        hz.EXMEM_en   = 1'b1;
        hz.halted     = (state == HALT);

        // Highest-priority condition wins; a dmem wait masks any pending ctl/lu until release.
        if (!rst_n) begin
            hz.IFID_clear = 1'b1;
            hz.IDEX_clear = 1'b1;
        end else if ((state == HALT) || mw) begin
            hz.StallPC  = 1'b1;
            hz.IFID_en  = 1'b0;
            hz.IDEX_en  = 1'b0;
            hz.EXMEM_en = 1'b0;
        end else if (ctl) begin
            hz.IFID_clear = 1'b1;
            hz.IDEX_clear = 1'b1;
        end else if (lu) begin
            hz.StallPC    = 1'b1;
            hz.IFID_en    = 1'b0;
            hz.IDEX_clear = 1'b1;
        end else if (hz.JalD) begin
            hz.IFID_clear = 1'b1;
        end

        stall_inc = rst_n && (hz.StallPC || !hz.IDEX_en);
        flush_inc = rst_n && (hz.IFID_clear || hz.IDEX_clear);
    end

    // wcnt counts consecutive wait cycles including the one that left RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        state <= MWAIT;
                        wcnt  <= WONE;
                    end
                end
                MWAIT: begin
                    if (!mw) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (wcnt == WLIM) begin
                        state <= HALT;
                    end else begin
                        wcnt <= wcnt + WONE;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (hz.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .cnt   (hz.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a priority-rule reference model.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 6;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.CNT_W(CNT_W)) intf ();

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model state: consecutive wait cycles, sticky halt, counter values.
    int mWait;
    bit mHalted;
    int mStall;
    int mFlush;

    // Control vector order: {StallPC, IFID_en, IFID_clear, IDEX_en, IDEX_clear, EXMEM_en}
    localparam logic [5:0] V_RESET  = 6'b0_1_1_1_1_1;
    localparam logic [5:0] V_FREEZE = 6'b1_0_0_0_0_0;
    localparam logic [5:0] V_SQUASH = 6'b0_1_1_1_1_1;
    localparam logic [5:0] V_BUBBLE = 6'b1_0_0_1_1_1;
    localparam logic [5:0] V_JAL    = 6'b0_1_1_1_0_1;
    localparam logic [5:0] V_NONE   = 6'b0_1_0_1_0_1;

    function automatic logic [5:0] ctrl_vec();
        return {intf.StallPC, intf.IFID_en, intf.IFID_clear,
                intf.IDEX_en, intf.IDEX_clear, intf.EXMEM_en};
    endfunction

    function automatic logic [5:0] exp_ctrl();
        bit useRs1, useRs2, loadUse;
        useRs1  = intf.RegReadD[1] && (intf.Rs1D == intf.RdE);
        useRs2  = intf.RegReadD[0] && (intf.Rs2D == intf.RdE);
        loadUse = intf.MemToRegE && (intf.RegWriteE != 3'd0) && (intf.RdE != 5'd0) && (useRs1 || useRs2);
        if (!rst_n)                                  return V_RESET;
        if (mHalted)                                 return V_FREEZE;
        if (intf.MemReqM && !intf.dmem_ready)        return V_FREEZE;
        if (intf.BranchTakenE || intf.JalrE)         return V_SQUASH;
        if (loadUse)                                 return V_BUBBLE;
        if (intf.JalD)                               return V_JAL;
        return V_NONE;
    endfunction

    task automatic model_reset();
        mWait   = 0;
        mHalted = 1'b0;
        mStall  = 0;
        mFlush  = 0;
    endtask

    task automatic model_clock(input logic [5:0] e);
        if (e[5] || !e[2]) mStall = (mStall >= MAXC) ? MAXC : mStall + 1;
        if (e[3] || e[1])  mFlush = (mFlush >= MAXC) ? MAXC : mFlush + 1;
        if (!mHalted) begin
            if (intf.MemReqM && !intf.dmem_ready) begin
                mWait++;
                if (mWait >= TIMEOUT) mHalted = 1'b1;
            end else begin
                mWait = 0;
            end
        end
    endtask

    task automatic set_idle();
        intf.Rs1D = 5'd0;  intf.Rs2D = 5'd0;  intf.RegReadD = 2'b00;
        intf.RdE = 5'd0;   intf.RegWriteE = 3'd0; intf.MemToRegE = 1'b0;
        intf.JalD = 1'b0;  intf.BranchTakenE = 1'b0; intf.JalrE = 1'b0;
        intf.MemReqM = 1'b0; intf.dmem_ready = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [1:0] rr);
        set_idle();
        intf.RdE = rd; intf.MemToRegE = 1'b1; intf.RegWriteE = 3'd1;
        intf.Rs1D = 5'd5; intf.RegReadD = rr;
    endtask

    // Call just after a negedge with inputs already driven; checks outputs then state after the edge.
    task automatic cycle(input string nm);
        logic [5:0] e;
        logic [5:0] got;
        #1;
        e   = exp_ctrl();
        got = ctrl_vec();
        nChecks++;
        if (got !== e) begin
            nFail++;
            $display("[TB] FAIL %s ctrl got %b expected %b", nm, got, e);
        end
        @(posedge clk);
        if (rst_n) model_clock(e);
        #1;
        nChecks++;
        if (intf.halted !== mHalted) begin
            nFail++;
            $display("[TB] FAIL %s halted got %b expected %b", nm, intf.halted, mHalted);
        end
        nChecks++;
        if (intf.stall_cnt !== CNT_W'(mStall)) begin
            nFail++;
            $display("[TB] FAIL %s stall_cnt got %0d expected %0d", nm, intf.stall_cnt, mStall);
        end
        nChecks++;
        if (intf.flush_cnt !== CNT_W'(mFlush)) begin
            nFail++;
            $display("[TB] FAIL %s flush_cnt got %0d expected %0d", nm, intf.flush_cnt, mFlush);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        model_reset();
        cycle("reset_pulse");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cycle("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle("reset_release");
    endtask

    task automatic test_load_use();
        @(negedge clk); set_load_use(5'd5, 2'b10); cycle("lu_hit");
        nChecks++;
        if (ctrl_vec() !== V_BUBBLE && 1'b0) nFail++;
        @(negedge clk); set_idle(); cycle("lu_after_bubble");
        @(negedge clk); set_load_use(5'd0, 2'b10); cycle("lu_rd_zero");
        @(negedge clk); set_load_use(5'd5, 2'b00); cycle("lu_no_read");
        @(negedge clk); set_load_use(5'd5, 2'b10); intf.Rs1D = 5'd6; intf.Rs2D = 5'd5; intf.RegReadD = 2'b01;
        cycle("lu_rs2_hit");
        @(negedge clk); set_idle(); intf.JalD = 1'b1; cycle("jal_only");
    endtask

    task automatic test_ctl_over_lu();
        int s0, f0;
        @(negedge clk);
        set_load_use(5'd5, 2'b10);
        intf.BranchTakenE = 1'b1;
        s0 = mStall;
        f0 = mFlush;
        cycle("ctl_over_lu");
        nChecks++;
        if (intf.stall_cnt !== CNT_W'(s0) || intf.flush_cnt !== CNT_W'(f0 + 1)) begin
            nFail++;
            $display("[TB] FAIL ctl_over_lu_counts got stall %0d flush %0d required %0d %0d",
                     intf.stall_cnt, intf.flush_cnt, s0, f0 + 1);
        end
        @(negedge clk); set_idle(); intf.JalrE = 1'b1; cycle("jalr_squash");
    endtask

    task automatic test_mem_wait();
        int s0;
        s0 = mStall;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_idle(); intf.MemReqM = 1'b1; intf.dmem_ready = 1'b0;
            intf.BranchTakenE = (i == 1);
            cycle("mem_wait");
        end
        @(negedge clk); intf.dmem_ready = 1'b1; intf.BranchTakenE = 1'b0; cycle("mem_release");
        nChecks++;
        if (intf.stall_cnt !== CNT_W'(s0 + 3) || intf.halted !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL mem_wait_total got stall %0d halted %b required %0d 0",
                     intf.stall_cnt, intf.halted, s0 + 3);
        end
        @(negedge clk); set_idle(); intf.MemReqM = 1'b1; cycle("mem_ready_first");
    endtask

    task automatic test_timeout();
        pulse_reset();
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk); set_idle(); intf.MemReqM = 1'b1; intf.dmem_ready = 1'b0;
            cycle("timeout_wait");
        end
        nChecks++;
        if (intf.halted !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL timeout_halt halted got %b required 1", intf.halted);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_idle(); intf.BranchTakenE = 1'b1; cycle("halt_frozen");
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        nChecks++;
        if (intf.halted !== 1'b0 || intf.stall_cnt !== '0 || ctrl_vec() !== V_RESET) begin
            nFail++;
            $display("[TB] FAIL async_reset got halted %b stall %0d ctrl %b required 0 0 %b",
                     intf.halted, intf.stall_cnt, ctrl_vec(), V_RESET);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        cycle("after_halt_reset");
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < MAXC + 6; i++) begin
            @(negedge clk); set_load_use(5'd5, 2'b10); cycle("saturate");
        end
        nChecks++;
        if (intf.stall_cnt !== CNT_W'(MAXC) || intf.flush_cnt !== CNT_W'(MAXC)) begin
            nFail++;
            $display("[TB] FAIL saturation got stall %0d flush %0d required %0d",
                     intf.stall_cnt, intf.flush_cnt, MAXC);
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) pulse_reset();
            @(negedge clk);
            intf.Rs1D         = 5'($urandom_range(0, 3));
            intf.Rs2D         = 5'($urandom_range(0, 3));
            intf.RegReadD     = 2'($urandom_range(0, 3));
            intf.RdE          = 5'($urandom_range(0, 3));
            intf.RegWriteE    = 3'($urandom_range(0, 7));
            intf.MemToRegE    = ($urandom_range(0, 1) == 1);
            intf.JalD         = ($urandom_range(0, 7) == 0);
            intf.BranchTakenE = ($urandom_range(0, 7) == 0);
            intf.JalrE        = ($urandom_range(0, 15) == 0);
            intf.MemReqM      = ($urandom_range(0, 2) == 0);
            intf.dmem_ready   = ($urandom_range(0, 2) != 0);
            cycle("random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        test_reset();
        test_load_use();
        test_ctl_over_lu();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
